// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {PC, NPC, IR} with a taken-branch flush.
// Define IFQ_BYPASS_EN to let an empty queue pass a fetched instruction straight to decode in the same cycle.
module if_id_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid_inst_in,
  input  logic [31:0]             if_PC_in,
  input  logic [31:0]             if_NPC_in,
  input  logic [31:0]             if_IR_in,
  output logic                    if_ready_out,
  input  logic                    ex_take_branch_out,
  input  logic                    id_ready_in,
  output logic                    id_valid_inst_out,
  output logic [31:0]             id_PC_out,
  output logic [31:0]             id_NPC_out,
  output logic [31:0]             id_IR_out,
  output logic [$clog2(DEPTH):0]  ifq_count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   npc_mem [DEPTH];
  logic [31:0]   ir_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_next;

  logic          queued;
  logic          bypass;
  logic          push;
  logic          pop;

  always_comb begin
    queued       = (count_reg != '0);
    if_ready_out = (count_reg < FULL_COUNT);
`ifdef IFQ_BYPASS_EN
    // Gated by rst so the outputs still read as idle while reset is held.
    bypass = rst && !queued && if_valid_inst_in && !ex_take_branch_out;
`else
    bypass = 1'b0;
`endif
    push = if_valid_inst_in && if_ready_out && !ex_take_branch_out && !(bypass && id_ready_in);
    pop  = queued && id_ready_in && !ex_take_branch_out;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (ex_take_branch_out) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + (PW+1)'(1);
        2'b01:   count_next = count_reg - (PW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]  <= if_PC_in;
      npc_mem[wr_ptr_reg] <= if_NPC_in;
      ir_mem[wr_ptr_reg]  <= if_IR_in;
    end
  end

  always_comb begin
    id_valid_inst_out = 1'b0;
    id_PC_out         = 32'h0;
    id_NPC_out        = 32'h0;
    id_IR_out         = NOP_INST;
    if (bypass) begin
      id_valid_inst_out = 1'b1;
      id_PC_out         = if_PC_in;
      id_NPC_out        = if_NPC_in;
      id_IR_out         = if_IR_in;
    end else if (queued) begin
      id_valid_inst_out = 1'b1;
      id_PC_out         = pc_mem[rd_ptr_reg];
      id_NPC_out        = npc_mem[rd_ptr_reg];
      id_IR_out         = ir_mem[rd_ptr_reg];
    end
    ifq_count_out = count_reg;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_id_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid_inst_in = 1'b0;
  logic [31:0] if_PC_in = '0, if_NPC_in = '0, if_IR_in = '0;
  logic        if_ready_out;
  logic        ex_take_branch_out = 1'b0;
  logic        id_ready_in = 1'b0;
  logic        id_valid_inst_out;
  logic [31:0] id_PC_out, id_NPC_out, id_IR_out;
  logic [$clog2(DEPTH):0] ifq_count_out;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .if_valid_inst_in(if_valid_inst_in), .if_PC_in(if_PC_in), .if_NPC_in(if_NPC_in), .if_IR_in(if_IR_in),
    .if_ready_out(if_ready_out), .ex_take_branch_out(ex_take_branch_out), .id_ready_in(id_ready_in),
    .id_valid_inst_out(id_valid_inst_out), .id_PC_out(id_PC_out), .id_NPC_out(id_NPC_out),
    .id_IR_out(id_IR_out), .ifq_count_out(ifq_count_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] npc; logic [31:0] ir; } ent_t;
  ent_t model_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, given the inputs currently driven.
  task automatic check_outputs(input string tag);
    logic        e_valid;
    logic [31:0] e_pc, e_npc, e_ir;
    e_valid = 1'b0; e_pc = 0; e_npc = 0; e_ir = NOP;
`ifdef IFQ_BYPASS_EN
    if (rst && model_q.size() == 0 && if_valid_inst_in && !ex_take_branch_out) begin
      e_valid = 1'b1; e_pc = if_PC_in; e_npc = if_NPC_in; e_ir = if_IR_in;
    end else
`endif
    if (model_q.size() != 0) begin
      e_valid = 1'b1; e_pc = model_q[0].pc; e_npc = model_q[0].npc; e_ir = model_q[0].ir;
    end
    check({tag, ".valid"}, 32'(id_valid_inst_out), 32'(e_valid));
    check({tag, ".pc"},    id_PC_out, e_pc);
    check({tag, ".npc"},   id_NPC_out, e_npc);
    check({tag, ".ir"},    id_IR_out, e_ir);
    check({tag, ".count"}, 32'(ifq_count_out), model_q.size());
    check({tag, ".ready"}, 32'(if_ready_out), 32'(model_q.size() < DEPTH));
  endtask

  // One clock cycle: drive at negedge, check, advance model, step to next negedge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ir,
                       input logic br, input logic idr);
    bit can_push, can_pop, consumed;
    if_valid_inst_in = v; if_PC_in = pc; if_NPC_in = pc + 32'd4; if_IR_in = ir;
    ex_take_branch_out = br; id_ready_in = idr;
    #1;
    check_outputs(tag);
    $display("cyc %-8s v=%0b pc=%h br=%0b idr=%0b -> valid=%0b head=%h cnt=%0d rdy=%0b",
             tag, v, pc, br, idr, id_valid_inst_out, id_PC_out, ifq_count_out, if_ready_out);
    if (br) begin
      model_q.delete();
    end else begin
      can_push = v && (model_q.size() < DEPTH);
      can_pop  = (model_q.size() != 0) && idr;
      consumed = 1'b0;
`ifdef IFQ_BYPASS_EN
      consumed = v && idr && (model_q.size() == 0);
`endif
      if (can_pop) void'(model_q.pop_front());
      if (can_push && !consumed) model_q.push_back('{pc, pc + 32'd4, ir});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held from time 0
    #2;
    check("rst.valid", 32'(id_valid_inst_out), 0);
    check("rst.ir",    id_IR_out, NOP);
    check("rst.ready", 32'(if_ready_out), 1);
    check("rst.count", 32'(ifq_count_out), 0);
    @(negedge clk);
    rst = 1'b1;

    // First push right after reset release, decode stalled
    cycle("first", 1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    check("first.valid", 32'(id_valid_inst_out), 1);
    check("first.pc",    id_PC_out, 32'h0);
    check("first.npc",   id_NPC_out, 32'h4);
    check("first.count", 32'(ifq_count_out), 1);

    // Fill to DEPTH; fifth offer dropped
    for (int k = 1; k <= 4; k++) begin
      cycle("fill", 1'b1, 32'(4 * k), 32'h100 + 32'(k), 1'b0, 1'b0);
      if (k == 3) check("full.ready", 32'(if_ready_out), 0);
    end
    check("full.count", 32'(ifq_count_out), 4);
    check("full.head",  id_PC_out, 32'h0);

    // Full: push and pop offered together, push refused
    cycle("fullpp", 1'b1, 32'h14, 32'h200, 1'b0, 1'b1);
    check("fullpp.count", 32'(ifq_count_out), 3);
    check("fullpp.head",  id_PC_out, 32'h4);

    // Flush with push offered
    cycle("flush", 1'b1, 32'h300, 32'h300, 1'b1, 1'b0);
    check("flush.count", 32'(ifq_count_out), 0);
    check("flush.valid", 32'(id_valid_inst_out), 0);
    check("flush.ir",    id_IR_out, 32'h0000_0013);
    check("flush.ready", 32'(if_ready_out), 1);

    // Ten push/pop pairs across pointer wrap
    cycle("wrap", 1'b1, 32'h0, 32'h400, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      check("wrap.head", id_PC_out, 32'(4 * (k - 1)));
      cycle("wrap", 1'b1, 32'(4 * k), 32'h400 + 32'(k), 1'b0, 1'b1);
    end
    check("wrap.last", id_PC_out, 32'h24);
    cycle("wrap", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("wrap.empty", 32'(ifq_count_out), 0);

    // Asynchronous reset between edges with two entries queued
    cycle("prerst", 1'b1, 32'h500, 32'h500, 1'b0, 1'b0);
    cycle("prerst", 1'b1, 32'h504, 32'h504, 1'b0, 1'b0);
    if_valid_inst_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    check("arst.valid", 32'(id_valid_inst_out), 0);
    check("arst.count", 32'(ifq_count_out), 0);
    check("arst.pc",    id_PC_out, 32'h0);
    check("arst.ir",    id_IR_out, NOP);
    check("arst.ready", 32'(if_ready_out), 1);
    @(negedge clk);
    rst = 1'b1;
    cycle("postrst", 1'b1, 32'h600, 32'h600, 1'b0, 1'b0);
    check("postrst.count", 32'(ifq_count_out), 1);
    check("postrst.head",  id_PC_out, 32'h600);
    cycle("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

`ifdef IFQ_BYPASS_EN
    // Empty queue, decode ready: same-cycle passthrough, nothing stored
    if_valid_inst_in = 1'b1; if_PC_in = 32'h700; if_NPC_in = 32'h704; if_IR_in = 32'h777;
    id_ready_in = 1'b1; ex_take_branch_out = 1'b0;
    #1;
    check("byp.valid", 32'(id_valid_inst_out), 1);
    check("byp.pc",    id_PC_out, 32'h700);
    @(posedge clk); #1;
    check("byp.count", 32'(ifq_count_out), 0);
    @(negedge clk);
`endif

    // Random traffic
    begin
      logic [31:0] pc_seq;
      pc_seq = 32'h1000;
      for (int i = 0; i < 400; i++) begin
        logic v, br, idr;
        v   = ($urandom_range(0, 9) < 7);
        idr = ($urandom_range(0, 9) < 5);
        br  = ($urandom_range(0, 19) == 0);
        cycle("rand", v, pc_seq, $urandom, br, idr);
        pc_seq = pc_seq + 32'd4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, 2 or greater.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, giving the instruction word driven when the output is invalid.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port if_valid_inst_in, input, 1 bit: the fetch stage offers an instruction this cycle.
REQ-006 The block SHALL have ports if_PC_in, if_NPC_in and if_IR_in, inputs, 32 bits each: the offered PC, PC+4 and instruction word.
REQ-007 The block SHALL have port if_ready_out, output, 1 bit: the queue accepts an offered instruction this cycle.
REQ-008 The block SHALL have port ex_take_branch_out, input, 1 bit: taken-branch flush request.
REQ-009 The block SHALL have port id_ready_in, input, 1 bit: the decode stage consumes the head entry this cycle.
REQ-010 The block SHALL have port id_valid_inst_out, output, 1 bit: the head entry is valid.
REQ-011 The block SHALL have ports id_PC_out, id_NPC_out and id_IR_out, outputs, 32 bits each: the head entry's PC, NPC and instruction.
REQ-012 The block SHALL have port ifq_count_out, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-013 The queue SHALL be a circular buffer of DEPTH entries of {PC, NPC, IR}, with write pointer, read pointer and occupancy count.
REQ-014 The pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-015 if_ready_out SHALL equal (count < DEPTH); a full queue SHALL deassert if_ready_out even when a pop occurs in the same cycle.
REQ-016 A push SHALL occur when if_valid_inst_in and if_ready_out are high and ex_take_branch_out is low, writing the entry at the write pointer and incrementing the write pointer.
REQ-017 A pop SHALL occur when id_valid_inst_out and id_ready_in are high and ex_take_branch_out is low, incrementing the read pointer.
REQ-018 On a simultaneous push and pop, count SHALL stay unchanged and both pointers SHALL advance.
REQ-019 id_valid_inst_out SHALL equal (count != 0), and id_PC_out, id_NPC_out and id_IR_out SHALL show the entry at the read pointer.
REQ-020 When id_valid_inst_out is low, id_PC_out and id_NPC_out SHALL be 0 and id_IR_out SHALL be NOP_INST.
REQ-021 Push-to-output latency SHALL be one cycle: an entry pushed at edge N is valid at the outputs from edge N onward.
REQ-022 When ex_take_branch_out is high at an edge, count and both pointers SHALL become 0; any offered push and any pop in that cycle SHALL be discarded.
REQ-023 Flush SHALL take priority over push and pop.
REQ-024 The cycle after a flush, the queue SHALL be empty and if_ready_out SHALL be 1.
REQ-025 The head entry SHALL remain stable while id_ready_in is low; no entry SHALL be overwritten while it is still queued.
REQ-026 Pop on an empty queue and push on a full queue SHALL change no state.

Reset
REQ-027 While rst is low, count, wr_ptr and rd_ptr SHALL be 0 immediately, independent of clk.
REQ-028 While rst is low, id_valid_inst_out SHALL be 0, id_PC_out and id_NPC_out SHALL be 0, id_IR_out SHALL be NOP_INST, if_ready_out SHALL be 1 and ifq_count_out SHALL be 0.
REQ-029 Assertion of rst mid-operation SHALL discard all queued entries; the stored payload array SHALL need no reset.
REQ-030 The first push SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-031 With macro IFQ_BYPASS_EN defined: when count==0, if_valid_inst_in=1 and ex_take_branch_out=0, the input fields SHALL drive the outputs combinationally and id_valid_inst_out SHALL be 1 in the same cycle.
REQ-032 In that IFQ_BYPASS_EN case, if id_ready_in=1 the instruction SHALL be consumed without being written; if id_ready_in=0 it SHALL be pushed normally.
REQ-033 Without IFQ_BYPASS_EN, outputs SHALL depend only on queue state (zero-latency path absent, minimum latency one cycle), and REQ-019 to REQ-021 SHALL apply unmodified.

Verification
REQ-034 The bench SHALL cover: reset release, then push PC=0x0, IR=0x00500093 with id_ready_in=0 -> next cycle id_valid_inst_out=1, id_PC_out=0x0, id_NPC_out=0x4, ifq_count_out=1.
REQ-035 The bench SHALL cover: DEPTH=4, five consecutive pushes with id_ready_in=0 -> if_ready_out=0 after the 4th, 5th dropped, count=4, head PC=0x0.
REQ-036 The bench SHALL cover: full queue, push and pop offered in the same cycle -> push refused, count=3, head PC=0x4.
REQ-037 The bench SHALL cover: queue holding 3 entries, ex_take_branch_out=1 with a push offered -> next cycle count=0, id_valid_inst_out=0, id_IR_out=0x00000013.
REQ-038 The bench SHALL cover: 10 push/pop pairs through DEPTH=4 -> pointer wrap with PCs 0x0..0x24 popped in order and none lost.
REQ-039 The bench SHALL cover: rst driven low between clock edges with count=2 -> outputs reset immediately; with IFQ_BYPASS_EN, an empty-queue push with id_ready_in=1 -> same-cycle id_valid_inst_out=1 and count stays 0.
